pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_pkg.sv | 43 ++++
 rtl/pipe_ctrl_if.sv | 38 +++
 rtl/pipe_ctrl_mc_timer.sv | 26 ++
 rtl/pipe_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline hazard controller: next-PC select,
// FSM state codes and the bundled control-output record.
package pipe_pkg;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEQ  = 2'b00;
  localparam pc_sel_t PC_BR   = 2'b01;
  localparam pc_sel_t PC_TRAP = 2'b10;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_WAIT = 1'b1;

  typedef struct packed {
    logic    pc_en;
    logic    if_id_en;
    logic    id_ex_en;
    logic    ex_mem_en;
    logic    mem_wb_en;
    logic    if_id_flush;
    logic    id_ex_flush;
    logic    ex_mem_flush;
    logic    mem_wb_flush;
    pc_sel_t pc_sel;
    logic    mc_busy;
    logic    mc_done;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

  // Free-running pipeline: everything advances, nothing is flushed.
  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c           = CTRL_OFF;
    c.pc_en     = 1'b1;
    c.if_id_en  = 1'b1;
    c.id_ex_en  = 1'b1;
    c.ex_mem_en = 1'b1;
    c.mem_wb_en = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the datapath and stall/flush/redirect controls back to it.
interface pipe_ctrl_if;
  import pipe_pkg::*;

  logic    lu_hazard;
  logic    br_taken;
  logic    trap;
  logic    mc_start;
  logic    mem_req;
  logic    mem_ready;

  logic    pc_en;
  logic    if_id_en;
  logic    id_ex_en;
  logic    ex_mem_en;
  logic    mem_wb_en;
  logic    if_id_flush;
  logic    id_ex_flush;
  logic    ex_mem_flush;
  logic    mem_wb_flush;
  pc_sel_t pc_sel;
  logic    mc_busy;
  logic    mc_done;

  modport master (
    output lu_hazard, br_taken, trap, mc_start, mem_req, mem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_sel, mc_busy, mc_done
  );

  modport slave (
    input  lu_hazard, br_taken, trap, mc_start, mem_req, mem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush,
           pc_sel, mc_busy, mc_done
  );
endinterface

// File: rtl/pipe_ctrl_mc_timer.sv
// Loadable down-counter for the multi-cycle unit; saturates at zero and
// exposes a zero flag. Clear wins over load, load wins over decrement.
module mc_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // NOTE: non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (dec && cnt != '0)    cnt <= cnt - CNT_W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: resolves trap, memory stall, multi-cycle wait,
// branch and load-use events into PC/pipeline-register enables and flushes.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MC_CYCLES = 32,
  parameter int CNT_W     = 8
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             mem_stall;
  logic             mc_load;
  ctrl_t            c;

  assign mem_stall = bus.mem_req && !bus.mem_ready;
  assign mc_load   = (state == ST_RUN) && bus.mc_start && !bus.trap && !mem_stall;

  mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.trap),
    .load     (mc_load),
    .load_val (MC_LOAD),
    .dec      (state == ST_MC_WAIT),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_RUN;
    else      state <= state_nxt;
  end

  // NOTE: every field gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    c         = ctrl_run();

    if (bus.trap) begin
      c.pc_sel       = PC_TRAP;
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
      state_nxt      = ST_RUN;
    end else if (mem_stall) begin
      c.pc_en        = 1'b0;
      c.if_id_en     = 1'b0;
      c.id_ex_en     = 1'b0;
      c.ex_mem_en    = 1'b0;
      c.mem_wb_flush = 1'b1;
      c.mc_busy      = (state == ST_MC_WAIT);
    end else if (state == ST_MC_WAIT) begin
      if (cnt_zero) begin
        c.mc_done = 1'b1;
        state_nxt = ST_RUN;
      end else begin
        c.pc_en        = 1'b0;
        c.if_id_en     = 1'b0;
        c.id_ex_en     = 1'b0;
        c.ex_mem_flush = 1'b1;
        c.mc_busy      = 1'b1;
      end
    end else begin
      if (bus.br_taken) begin
        c.pc_sel      = PC_BR;
        c.if_id_flush = 1'b1;
        c.id_ex_flush = 1'b1;
      end else if (bus.lu_hazard) begin
        c.pc_en       = 1'b0;
        c.if_id_en    = 1'b0;
        c.id_ex_flush = 1'b1;
      end
      if (bus.mc_start) state_nxt = ST_MC_WAIT;
    end

    // Held in reset: the pipeline is frozen and nothing is redirected.
    if (!rst) c = CTRL_OFF;
  end

  assign bus.pc_en        = c.pc_en;
  assign bus.if_id_en     = c.if_id_en;
  assign bus.id_ex_en     = c.id_ex_en;
  assign bus.ex_mem_en    = c.ex_mem_en;
  assign bus.mem_wb_en    = c.mem_wb_en;
  assign bus.if_id_flush  = c.if_id_flush;
  assign bus.id_ex_flush  = c.id_ex_flush;
  assign bus.ex_mem_flush = c.ex_mem_flush;
  assign bus.mem_wb_flush = c.mem_wb_flush;
  assign bus.pc_sel       = c.pc_sel;
  assign bus.mc_busy      = c.mc_busy;
  assign bus.mc_done      = c.mc_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: two instances (MC_CYCLES=4 and 1) share stimulus;
// expected control words are queued as stimulus is applied and checked mid-cycle.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  pipe_ctrl_if bus4 ();
  pipe_ctrl_if bus1 ();

  assign bus1.lu_hazard = bus4.lu_hazard;
  assign bus1.br_taken  = bus4.br_taken;
  assign bus1.trap      = bus4.trap;
  assign bus1.mc_start  = bus4.mc_start;
  assign bus1.mem_req   = bus4.mem_req;
  assign bus1.mem_ready = bus4.mem_ready;

  pipe_ctrl #(.MC_CYCLES(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  pipe_ctrl #(.MC_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Input word: {lu_hazard, br_taken, trap, mc_start, mem_req, mem_ready}
  localparam logic [5:0] I_IDLE = 6'b000000;
  localparam logic [5:0] I_LU   = 6'b100000;
  localparam logic [5:0] I_BR   = 6'b010000;
  localparam logic [5:0] I_TRAP = 6'b001000;
  localparam logic [5:0] I_MCS  = 6'b000100;
  localparam logic [5:0] I_MSTL = 6'b000010;
  localparam logic [5:0] I_MRDY = 6'b000011;

  // Control word: {pc,if_id,id_ex,ex_mem,mem_wb en}, {if_id,id_ex,ex_mem,mem_wb flush}, pc_sel, busy, done
  localparam logic [12:0] E_RST    = {5'b00000, 4'b0000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_NORM   = {5'b11111, 4'b0000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_LU     = {5'b00111, 4'b0100, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_BR     = {5'b11111, 4'b1100, 2'b01, 1'b0, 1'b0};
  localparam logic [12:0] E_TRAP   = {5'b11111, 4'b1110, 2'b10, 1'b0, 1'b0};
  localparam logic [12:0] E_MSTL   = {5'b00001, 4'b0001, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_MSTLMC = {5'b00001, 4'b0001, 2'b00, 1'b1, 1'b0};
  localparam logic [12:0] E_MCWAIT = {5'b00011, 4'b0010, 2'b00, 1'b1, 1'b0};
  localparam logic [12:0] E_DONE   = {5'b11111, 4'b0000, 2'b00, 1'b0, 1'b1};

  typedef struct {
    string       tag;
    int          dut;
    logic [12:0] val;
  } sb_t;

  sb_t q[$];
  int  total  = 0;
  int  passed = 0;

  function automatic logic [12:0] obs(input int d);
    if (d == 1)
      return {bus1.pc_en, bus1.if_id_en, bus1.id_ex_en, bus1.ex_mem_en, bus1.mem_wb_en,
              bus1.if_id_flush, bus1.id_ex_flush, bus1.ex_mem_flush, bus1.mem_wb_flush,
              bus1.pc_sel, bus1.mc_busy, bus1.mc_done};
    return {bus4.pc_en, bus4.if_id_en, bus4.id_ex_en, bus4.ex_mem_en, bus4.mem_wb_en,
            bus4.if_id_flush, bus4.id_ex_flush, bus4.ex_mem_flush, bus4.mem_wb_flush,
            bus4.pc_sel, bus4.mc_busy, bus4.mc_done};
  endfunction

  task automatic drive(input logic [5:0] v);
    bus4.lu_hazard = v[5];
    bus4.br_taken  = v[4];
    bus4.trap      = v[3];
    bus4.mc_start  = v[2];
    bus4.mem_req   = v[1];
    bus4.mem_ready = v[0];
  endtask

  task automatic push(input string tag, input int d, input logic [12:0] e);
    sb_t s;
    s.tag = tag;
    s.dut = d;
    s.val = e;
    q.push_back(s);
  endtask

  task automatic settle();
    sb_t s;
    logic [12:0] o;
    while (q.size() > 0) begin
      s = q.pop_front();
      o = obs(s.dut);
      total++;
      assert (o === s.val) passed++;
      else $error("FAIL %s (dut MC_CYCLES=%0d): observed %b expected %b", s.tag, s.dut, o, s.val);
    end
  endtask

  task automatic cyc(input logic [5:0] v);
    @(posedge clk);
    #1;
    drive(v);
  endtask

  task automatic sample();
    @(negedge clk);
    settle();
  endtask

  task automatic step(input logic [5:0] v, input string tag, input logic [12:0] e);
    cyc(v);
    push(tag, 4, e);
    sample();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(I_IDLE);

    // Reset held: everything frozen.
    repeat (2) @(negedge clk);
    push("reset_state", 4, E_RST);
    push("reset_state", 1, E_RST);
    settle();
    rst = 1'b1;

    for (int i = 0; i < 5; i++) step(I_IDLE, "idle", E_NORM);

    // MC_CYCLES=1 alongside MC_CYCLES=4 from the same mc_start.
    cyc(I_MCS);  push("mc1_start", 1, E_NORM); push("mc4_start", 4, E_NORM);   sample();
    cyc(I_IDLE); push("mc1_done", 1, E_DONE);  push("mc4_wait1", 4, E_MCWAIT); sample();
    cyc(I_IDLE); push("mc1_run", 1, E_NORM);   push("mc4_wait2", 4, E_MCWAIT); sample();
    step(I_BR | I_MCS | I_LU, "mc4_wait3_ignores_br", E_MCWAIT);
    step(I_IDLE, "mc4_done", E_DONE);
    step(I_IDLE, "mc4_back_to_run", E_NORM);

    // Single-cycle events in RUN.
    step(I_LU,           "lu_hazard",      E_LU);
    step(I_IDLE,         "after_lu",       E_NORM);
    step(I_BR | I_LU,    "br_over_lu",     E_BR);
    step(I_MSTL,         "mem_stall",      E_MSTL);
    step(I_MSTL | I_BR,  "stall_over_br",  E_MSTL);
    step(I_MRDY,         "mem_ready",      E_NORM);
    step(I_TRAP | I_MSTL,"trap_over_stall",E_TRAP);
    step(I_IDLE,         "after_trap",     E_NORM);

    // Memory stall on cycles 2-6 after mc_start delays completion.
    step(I_MCS,  "ms_start", E_NORM);
    step(I_IDLE, "ms_wait1", E_MCWAIT);
    for (int i = 2; i <= 6; i++) step(I_MSTL, "ms_stalled", E_MSTLMC);
    step(I_MRDY, "ms_done_on_ready", E_DONE);
    step(I_IDLE, "ms_run", E_NORM);

    // Trap with br_taken in the would-be completion cycle aborts the wait.
    step(I_MCS, "tr_start", E_NORM);
    for (int i = 1; i <= 3; i++) step(I_IDLE, "tr_wait", E_MCWAIT);
    step(I_TRAP | I_BR, "tr_abort", E_TRAP);
    step(I_IDLE, "tr_run", E_NORM);
    step(I_IDLE, "tr_no_late_done", E_NORM);

    // Asynchronous reset in the middle of a wait.
    step(I_MCS,  "ar_start", E_NORM);
    step(I_IDLE, "ar_wait1", E_MCWAIT);
    #1;
    rst = 1'b0;
    #1;
    push("rst_async", 4, E_RST);
    push("rst_async", 1, E_RST);
    settle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      push("rst_hold", 4, E_RST);
      settle();
    end
    rst = 1'b1;
    cyc(I_IDLE); push("ar_run", 4, E_NORM); push("ar_run", 1, E_NORM); sample();
    step(I_IDLE, "ar_no_done", E_NORM);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
